// File: rtl/prog_mem_resp.sv
// Word-addressed program memory with a fetch read port (optional wait states,
// one-cycle registered response, range/alignment error) and a program-load write port.
module prog_mem_resp #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(32'h0000_0000),
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pm_rd_i,
    input  logic [XLEN-1:0] pm_addr_i,
    output logic            pm_ready_o,
    output logic            pm_instr_valid_o,
    output logic [XLEN-1:0] pm_instr_o,
    output logic            pm_err_o,
    input  logic            load_we_i,
    input  logic [XLEN-1:0] load_addr_i,
    input  logic [XLEN-1:0] load_data_i
);

    localparam int unsigned     OFF_BITS = $clog2(XLEN / 8);
    localparam int unsigned     IDX_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [XLEN-1:0] DEPTH_X  = XLEN'(DEPTH_WORDS);
    localparam logic [3:0]      WAIT_LIM = 4'(WAIT_STATES);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [XLEN-1:0] rd_idx;
    logic [XLEN-1:0] ld_idx;
    logic            rd_in_range;
    logic            ld_in_range;
    logic            accept;

    // Index uses wrap-around subtraction, so addresses below BASE_ADDR land far out of range.
    assign rd_idx      = (pm_addr_i - BASE_ADDR) >> OFF_BITS;
    assign ld_idx      = (load_addr_i - BASE_ADDR) >> OFF_BITS;
    assign rd_in_range = (rd_idx < DEPTH_X) && (pm_addr_i[OFF_BITS-1:0] == '0);
    assign ld_in_range = (ld_idx < DEPTH_X) && (load_addr_i[OFF_BITS-1:0] == '0);

    assign pm_ready_o = (WAIT_STATES == 0) ||
                        ((state == WAIT) && (wait_cnt == WAIT_LIM) && pm_rd_i);
    assign accept     = pm_rd_i && pm_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pm_rd_i && (WAIT_STATES != 0)) begin
                        state    <= WAIT;
                        wait_cnt <= 4'd1;
                    end
                end
                WAIT: begin
                    if (!pm_rd_i || pm_ready_o) begin
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; contents are defined only by loads.
    always_ff @(posedge clk_i) begin
        if (load_we_i && ld_in_range) begin
            mem[ld_idx[IDX_BITS-1:0]] <= load_data_i;
        end
    end

    // Reads the pre-edge array contents, giving read-before-write on a same-word load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pm_instr_valid_o <= 1'b0;
            pm_err_o         <= 1'b0;
            pm_instr_o       <= '0;
        end else begin
            pm_instr_valid_o <= accept;
            pm_err_o         <= accept && !rd_in_range;
            if (accept) begin
                pm_instr_o <= rd_in_range ? mem[rd_idx[IDX_BITS-1:0]] : '0;
            end
        end
    end

endmodule
